mem_bus_master: RTL and testbench

- CPU-side initiator for the word-addressed memory bus.
- Accepts single read/write requests from the microcoded core over a valid/ready handshake.
- Drives the memory's address, write-enable and write-data lines, inserts a programmable number of wait states, and returns read data with a one-cycle response pulse.
- Sits between the CPU sequencer and the RAM responder; it is the first block to exercise the RAM write port.

---
 rtl/mem_bus_master.sv | 131 +++++++++++++
 tb/tb_mem_bus_master.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_master.sv
// mem_bus_master: CPU-side initiator for the word-addressed memory bus.
// Accepts one read/write request at a time over valid/ready, drives a
// registered address/write-data/write-strobe to memory, waits WAIT_STATES
// cycles, then returns a one-cycle response pulse with captured read data.
// Optional feature: define MEM_BUS_RANGE_CHECK_EN to flag addresses
// >= MEM_WORDS (suppressed write strobe, zero read data, rsp_err=1).
module mem_bus_master #(
    parameter int ADDR_W      = 17,
    parameter int DATA_W      = 32,
    parameter int WAIT_STATES = 1,
    parameter int MEM_WORDS   = 128
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_write_en,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
`ifdef MEM_BUS_RANGE_CHECK_EN
    output logic              rsp_err,
`endif
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    state_t     state_reg;
    state_t     state_next;
    logic [3:0] cnt_reg;
    logic       write_reg;
    logic       bad_reg;
    logic       req_bad;
    logic       accept;
    logic       enter_access;
    logic       op_write;
    logic       op_bad;

`ifdef MEM_BUS_RANGE_CHECK_EN
    localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_WORDS);
    assign req_bad = ({1'b0, req_addr} >= MEM_LIMIT);
`else
    logic unused_cfg;
    assign unused_cfg = (MEM_WORDS > 0);
    assign req_bad    = 1'b0;
`endif

    assign req_ready = (state_reg == ST_IDLE);
    assign busy      = (state_reg != ST_IDLE);

    // Next-state logic; the strobe for the ACCESS cycle is decided from the
    // request being accepted (IDLE) or the latched flags (WAIT).
    always_comb begin
        state_next   = state_reg;
        accept       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (req_valid) begin
                    accept     = 1'b1;
                    state_next = (WAIT_LOAD == 4'd0) ? ST_ACCESS : ST_WAIT;
                end
            end
            ST_WAIT: begin
                // The counter reaches zero on this edge: enter ACCESS now.
                if (cnt_reg <= 4'd1) begin
                    state_next = ST_ACCESS;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        enter_access = (state_next == ST_ACCESS) && (state_reg != ST_ACCESS);
        op_write     = (state_reg == ST_IDLE) ? req_write : write_reg;
        op_bad       = (state_reg == ST_IDLE) ? req_bad   : bad_reg;
    end

    // State register and registered bus/response datapath.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= 4'd0;
            write_reg    <= 1'b0;
            bad_reg      <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            mem_address  <= '0;
            mem_write_en <= 1'b0;
            mem_wdata    <= '0;
`ifdef MEM_BUS_RANGE_CHECK_EN
            rsp_err      <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            rsp_valid    <= 1'b0;
            mem_write_en <= enter_access && op_write && !op_bad;
`ifdef MEM_BUS_RANGE_CHECK_EN
            rsp_err      <= 1'b0;
`endif
            if (accept) begin
                mem_address <= req_addr;
                mem_wdata   <= req_wdata;
                write_reg   <= req_write;
                bad_reg     <= req_bad;
                cnt_reg     <= WAIT_LOAD;
            end else if (state_reg == ST_WAIT) begin
                cnt_reg <= cnt_reg - 4'd1;
            end
            if (state_reg == ST_ACCESS) begin
                rsp_valid <= 1'b1;
                if (!write_reg) begin
                    rsp_rdata <= bad_reg ? '0 : mem_rdata;
                end
`ifdef MEM_BUS_RANGE_CHECK_EN
                rsp_err <= bad_reg;
`endif
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_master.sv
// tb_mem_bus_master: three instances (WAIT_STATES 0, 1, 3), each with its
// own behavioural RAM; directed plus randomized requests checked against a
// scoreboard memory and the latency/strobe timing rules.
// Honors MEM_BUS_RANGE_CHECK_EN like the design.
module tb_mem_bus_master;

    localparam int AW = 17;
    localparam int DW = 32;

    logic clock = 1'b0;
    logic reset;
    logic preload;
    always #5 clock = ~clock;

    logic [2:0]    req_valid, req_ready, req_write, rsp_valid, mem_write_en, busy, rsp_err;
    logic [AW-1:0] req_addr [3];
    logic [AW-1:0] mem_address [3];
    logic [DW-1:0] req_wdata [3];
    logic [DW-1:0] rsp_rdata [3];
    logic [DW-1:0] mem_wdata [3];
    logic [DW-1:0] mem_rdata [3];

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] model_mem [int];
    logic [DW-1:0] last_rd [3];

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : (d == 1) ? 1 : 3;
    endfunction

    function automatic logic [DW-1:0] pre(input int d, input int i);
        return 32'hA000_0000 + (d << 16) + (i & 255);
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dut
            logic [DW-1:0] ram [256];

            mem_bus_master #(
                .ADDR_W(AW), .DATA_W(DW),
                .WAIT_STATES((gi == 0) ? 0 : (gi == 1) ? 1 : 3),
                .MEM_WORDS(128)
            ) u_dut (
                .clock(clock), .reset(reset),
                .req_valid(req_valid[gi]), .req_ready(req_ready[gi]),
                .req_write(req_write[gi]), .req_addr(req_addr[gi]),
                .req_wdata(req_wdata[gi]), .rsp_valid(rsp_valid[gi]),
                .rsp_rdata(rsp_rdata[gi]), .mem_address(mem_address[gi]),
                .mem_write_en(mem_write_en[gi]), .mem_wdata(mem_wdata[gi]),
                .mem_rdata(mem_rdata[gi]),
`ifdef MEM_BUS_RANGE_CHECK_EN
                .rsp_err(rsp_err[gi]),
`endif
                .busy(busy[gi])
            );
`ifndef MEM_BUS_RANGE_CHECK_EN
            assign rsp_err[gi] = 1'b0;
`endif
            // RAM responder: combinational read, write commits on the edge.
            always @(posedge clock) begin
                if (preload) begin
                    for (int i = 0; i < 256; i++) ram[i] <= pre(gi, i);
                end else if (mem_write_en[gi]) begin
                    ram[mem_address[gi][7:0]] <= mem_wdata[gi];
                end
            end
            assign mem_rdata[gi] = ram[mem_address[gi][7:0]];
        end
    endgenerate

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_rd(input int d, input logic [AW-1:0] a);
        int key = d * (1 << AW) + int'(a);
        if (model_mem.exists(key)) return model_mem[key];
        return pre(d, int'(a[7:0]));
    endfunction

    function automatic logic is_bad(input logic [AW-1:0] a);
`ifdef MEM_BUS_RANGE_CHECK_EN
        return (a >= 17'd128);
`else
        return 1'b0;
`endif
    endfunction

    // Issue one request; edges are numbered from the accept edge (edge 1).
    task automatic do_req(input int d, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, output logic [DW-1:0] rd,
                          output int lat, output int we_n, output int we_k,
                          output logic rdy_at, output logic err);
        lat = 0; we_n = 0; we_k = 0; rd = '0; rdy_at = 1'b0; err = 1'b0;
        @(negedge clock);
        for (int k = 0; k < 20 && !req_ready[d]; k++) @(negedge clock);
        req_valid[d] = 1'b1; req_write[d] = wr; req_addr[d] = a; req_wdata[d] = wd;
        @(posedge clock); #1;
        req_valid[d] = 1'b0;
        for (int k2 = 1; k2 <= 40; k2++) begin
            if (mem_write_en[d]) begin
                we_n++;
                if (we_k == 0) we_k = k2;
            end
            if (rsp_valid[d]) begin
                lat = k2; rd = rsp_rdata[d]; rdy_at = req_ready[d]; err = rsp_err[d];
                break;
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic run_op(input int d, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd);
        logic [DW-1:0] rd;
        int lat, we_n, we_k;
        logic rdy_at, err, bad;
        bad = is_bad(a);
        do_req(d, wr, a, wd, rd, lat, we_n, we_k, rdy_at, err);
        $display("[TB] dut%0d %s addr=%05h wdata=%08h -> lat=%0d rdata=%08h err=%0d",
                 d, wr ? "WR" : "RD", a, wd, lat, rd, err);
        chk("latency", lat, ws_of(d) + 2);
        chk("ready_with_rsp", rdy_at, 1);
        chk("rsp_err", err, bad);
        if (wr) begin
            chk("we_cycles", we_n, bad ? 0 : 1);
            if (!bad) begin
                chk("we_edge", we_k, ws_of(d) + 1);
                model_mem[d * (1 << AW) + int'(a)] = wd;
            end
            chk("rdata_hold", rd, last_rd[d]);
        end else begin
            chk("we_on_read", we_n, 0);
            chk("rdata", rd, bad ? '0 : model_rd(d, a));
            last_rd[d] = bad ? '0 : model_rd(d, a);
        end
        @(posedge clock); #1;
        chk("rsp_one_cycle", rsp_valid[d], 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r1, r2, e, cnt;
        logic b2;
        logic [DW-1:0] rd;
        reset = 1'b1; preload = 1'b1;
        req_valid = '0; req_write = '0;
        for (int d = 0; d < 3; d++) begin
            req_addr[d] = '0; req_wdata[d] = '0; last_rd[d] = '0;
        end
        repeat (3) @(posedge clock);
        @(negedge clock);
        preload = 1'b0;
        reset = 1'b0;
        @(posedge clock); #1;

        // Reset state
        for (int d = 0; d < 3; d++) begin
            chk("rst_ready", req_ready[d], 1);
            chk("rst_busy", busy[d], 0);
            chk("rst_rsp_valid", rsp_valid[d], 0);
            chk("rst_we", mem_write_en[d], 0);
            chk("rst_addr", mem_address[d], 0);
            chk("rst_rdata", rsp_rdata[d], 0);
            chk("rst_err", rsp_err[d], 0);
        end

        // Write then read back, rdata held through a following write
        run_op(1, 1'b1, 17'h00005, 32'hDEADBEEF);
        chk("ram5", g_dut[1].ram[5], 32'hDEADBEEF);
        run_op(1, 1'b0, 17'h00005, 32'h0);
        run_op(1, 1'b1, 17'h00006, 32'h01020304);
        chk("rdata_still", rsp_rdata[1], 32'hDEADBEEF);

        // Back-to-back: write 0x10 then read 0x10 with valid held high
        @(negedge clock);
        req_valid[1] = 1'b1; req_write[1] = 1'b1; req_addr[1] = 17'h10; req_wdata[1] = 32'h12345678;
        @(posedge clock); #1;
        req_write[1] = 1'b0; req_wdata[1] = 32'h0;
        r1 = 0; r2 = 0; b2 = 1'b0; rd = '0;
        for (e = 2; e < 30; e++) begin
            @(posedge clock); #1;
            if (r1 != 0 && e == r1 + 1) begin
                b2 = busy[1];
                req_valid[1] = 1'b0;
            end
            if (rsp_valid[1]) begin
                if (r1 == 0) r1 = e;
                else begin
                    r2 = e; rd = rsp_rdata[1];
                    break;
                end
            end
        end
        req_valid[1] = 1'b0;
        $display("[TB] dut1 back-to-back WR/RD 00010 -> rsp edges %0d,%0d rdata=%08h", r1, r2, rd);
        chk("b2b_first_rsp", r1, 3);
        chk("b2b_second_accept", b2, 1);
        chk("b2b_second_rsp", r2, 6);
        chk("b2b_rdata", rd, 32'h12345678);
        chk("b2b_ram", g_dut[1].ram[16], 32'h12345678);
        model_mem[1 * (1 << AW) + 16] = 32'h12345678;
        last_rd[1] = 32'h12345678;

        // Wait-state variants reading a preloaded word
        run_op(0, 1'b0, 17'h00007, 32'h0);
        run_op(2, 1'b0, 17'h00007, 32'h0);

        // Reset during WAIT of a read on the WS=3 instance
        @(negedge clock);
        req_valid[2] = 1'b1; req_write[2] = 1'b0; req_addr[2] = 17'h00009;
        @(posedge clock); #1;
        req_valid[2] = 1'b0;
        chk("abort_busy_before", busy[2], 1);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        chk("abort_busy", busy[2], 0);
        chk("abort_ready", req_ready[2], 1);
        chk("abort_rsp", rsp_valid[2], 0);
        chk("abort_rdata", rsp_rdata[2], 0);
        @(negedge clock);
        reset = 1'b0;
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clock); #1;
            if (rsp_valid[2]) cnt++;
        end
        $display("[TB] dut2 RD 00009 aborted by reset -> late rsp pulses=%0d", cnt);
        chk("abort_no_rsp", cnt, 0);
        for (int d = 0; d < 3; d++) last_rd[d] = '0;

`ifdef MEM_BUS_RANGE_CHECK_EN
        run_op(1, 1'b1, 17'h00080, 32'hCAFEF00D);
        chk("oor_ram", g_dut[1].ram[128], pre(1, 128));
        run_op(1, 1'b0, 17'h00090, 32'h0);
        run_op(1, 1'b0, 17'h0007F, 32'h0);
`endif

        // Randomized traffic on every instance
        for (int d = 0; d < 3; d++) begin
            for (int n = 0; n < 10; n++) begin
                run_op(d, 1'($urandom % 2), 17'($urandom % 16), $urandom);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
